// File: rtl/tx_ordered_set_sequencer.sv
// 1000BASE-X style TX ordered-set sequencer: idle K28.5/D16.2 pairs, /S/ payload /T/ /R/ framing ahead of the 8b/10b encoder.
// Optional macro TX_SEQ_ERROR_PROP_EN adds in_error, which turns an accepted byte into /V/.
module tx_ordered_set_sequencer #(
  parameter int IPG_PAIRS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
`ifdef TX_SEQ_ERROR_PROP_EN
  input  logic       in_error,
`endif
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_is_ctl,
  output logic       out_force_neg,
  output logic       busy
);

  localparam int CW = (IPG_PAIRS < 2) ? 1 : $clog2(IPG_PAIRS + 1);
  localparam logic [CW-1:0] IPG_MAX = CW'(IPG_PAIRS);

  localparam logic [7:0] SYM_K285 = 8'hBC;
  localparam logic [7:0] SYM_D162 = 8'h50;
  localparam logic [7:0] SYM_S    = 8'hFB;
  localparam logic [7:0] SYM_T    = 8'hFD;
  localparam logic [7:0] SYM_R    = 8'hF7;
  localparam logic [7:0] SYM_V    = 8'hFE;

  // Each state names the symbol that goes out on the next clock.
  typedef enum logic [2:0] {IDLE_K, IDLE_D, SOF, DATA, EOF_T, EXT_R} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   ipg_cnt, ipg_nxt;
  logic            parity;
  logic            prev_ext;
  logic            byte_err;
  logic [7:0]      data_p0;
  logic            ctl_p0, force_p0, busy_p0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= IPG_MAX) ? IPG_MAX : c + CW'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    ipg_nxt   = ipg_cnt;
    data_p0   = SYM_K285;
    ctl_p0    = 1'b1;
    force_p0  = 1'b0;
    busy_p0   = 1'b0;
    in_ready  = 1'b0;
`ifdef TX_SEQ_ERROR_PROP_EN
    byte_err  = in_error;
`else
    byte_err  = 1'b0;
`endif
    case (state)
      IDLE_K: begin
        force_p0  = prev_ext;
        state_nxt = IDLE_D;
      end
      IDLE_D: begin
        data_p0   = SYM_D162;
        ctl_p0    = 1'b0;
        ipg_nxt   = sat_inc(ipg_cnt);
        state_nxt = (tx_en && in_valid && ipg_nxt == IPG_MAX) ? SOF : IDLE_K;
      end
      SOF: begin
        data_p0   = SYM_S;
        busy_p0   = 1'b1;
        ipg_nxt   = '0;
        state_nxt = DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        busy_p0  = 1'b1;
        data_p0  = SYM_V;
        if (in_valid) begin
          if (!byte_err) begin
            data_p0 = in_data;
            ctl_p0  = 1'b0;
          end
          if (in_last) state_nxt = EOF_T;
        end
      end
      EOF_T: begin
        data_p0   = SYM_T;
        busy_p0   = 1'b1;
        state_nxt = EXT_R;
      end
      EXT_R: begin
        // parity is the slot now on the wire; the /R/ lands in the other one.
        data_p0   = SYM_R;
        busy_p0   = 1'b1;
        state_nxt = parity ? EXT_R : IDLE_K;
      end
      default: state_nxt = IDLE_K;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE_D;
      ipg_cnt       <= IPG_MAX;
      parity        <= 1'b0;
      prev_ext      <= 1'b0;
      out_data      <= SYM_K285;
      out_is_ctl    <= 1'b1;
      out_force_neg <= 1'b1;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      ipg_cnt       <= ipg_nxt;
      parity        <= ~parity;
      prev_ext      <= (state == EXT_R);
      out_data      <= data_p0;
      out_is_ctl    <= ctl_p0;
      out_force_neg <= force_p0;
      busy          <= busy_p0;
    end
  end

endmodule

// File: tb/tb_tx_ordered_set_sequencer.sv
// Randomized scoreboard bench for tx_ordered_set_sequencer; a slot-level symbol model predicts every output cycle.
// Build with TX_SEQ_ERROR_PROP_EN defined to also exercise in_error.
module tb_tx_ordered_set_sequencer;

  localparam int IPG = 2;

  logic       clk;
  logic       rst_n;
  logic       tx_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
`ifdef TX_SEQ_ERROR_PROP_EN
  logic       in_error;
  logic [15:0] err_mask;
`endif
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_is_ctl;
  logic       out_force_neg;
  logic       busy;

  tx_ordered_set_sequencer #(.IPG_PAIRS(IPG)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_en(tx_en),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
`ifdef TX_SEQ_ERROR_PROP_EN
    .in_error(in_error),
`endif
    .in_ready(in_ready),
    .out_data(out_data),
    .out_is_ctl(out_is_ctl),
    .out_force_neg(out_force_neg),
    .busy(busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       ctl;
    logic       frc;
    logic       bsy;
    logic       rdy;
  } sym_t;

  localparam sym_t RST_SYM = '{8'hBC, 1'b1, 1'b1, 1'b0, 1'b0};

  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 0;
  sym_t exp_q[$];

  logic [7:0] fbuf [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference model: slot index of the symbol on the wire, first idle slot after the
  // last frame, and the fixed tail (/T/ /R/ [/R/]) still to be sent.
  int         m_slot;
  int         m_gap;
  bit         m_pay;
  bit         m_sof;
  logic [7:0] m_tail[$];

  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst_n) begin
        m_slot = 0;
        m_gap  = -1000000;
        m_pay  = 0;
        m_sof  = 0;
        m_tail.delete();
        exp_q.delete();
        exp_q.push_back(RST_SYM);
      end else begin
        int   n;
        bit   err;
        sym_t e;
        n   = m_slot + 1;
        e   = '0;
        err = 0;
`ifdef TX_SEQ_ERROR_PROP_EN
        err = in_error;
`endif
        if (m_sof) begin
          e.data = 8'hFB; e.ctl = 1; e.bsy = 1;
          m_sof = 0;
          m_pay = 1;
        end else if (m_pay) begin
          e.bsy = 1;
          if (in_valid) begin
            if (err) begin e.data = 8'hFE; e.ctl = 1; end
            else     begin e.data = in_data; e.ctl = 0; end
            if (in_last) begin
              m_pay = 0;
              m_tail.push_back(8'hFD);
              m_tail.push_back(8'hF7);
              // the last /R/ must occupy an odd slot
              if (n % 2 == 0) m_tail.push_back(8'hF7);
              m_gap = n + 1 + m_tail.size();
            end
          end else begin
            e.data = 8'hFE; e.ctl = 1;
          end
        end else if (m_tail.size() > 0) begin
          e.data = m_tail.pop_front(); e.ctl = 1; e.bsy = 1;
        end else if (n % 2 == 0) begin
          e.data = 8'hBC; e.ctl = 1; e.frc = (n == m_gap);
        end else begin
          e.data = 8'h50; e.ctl = 0;
          if (tx_en && in_valid && (n + 1 - m_gap) / 2 >= IPG) m_sof = 1;
        end
        e.rdy  = m_pay;
        exp_q.push_back(e);
        m_slot = n;
      end
    end
  end

  // Monitor: one symbol per clock, compared away from the active edge.
  always @(negedge clk) begin
    if (mon_on) begin
      sym_t got;
      sym_t want;
      got = '{out_data, out_is_ctl, out_force_neg, busy, in_ready};
      if (!rst_n) begin
        total++;
        if (got !== RST_SYM) begin
          bad++;
          $display("FAIL reset_state t=%0t: got d=%h ctl=%b frc=%b busy=%b rdy=%b, want d=bc ctl=1 frc=1 busy=0 rdy=0",
                   $time, got.data, got.ctl, got.frc, got.bsy, got.rdy);
        end
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty t=%0t: got d=%h with no expected symbol", $time, got.data);
      end else begin
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL symbol t=%0t: got d=%h ctl=%b frc=%b busy=%b rdy=%b, want d=%h ctl=%b frc=%b busy=%b rdy=%b",
                   $time, got.data, got.ctl, got.frc, got.bsy, got.rdy,
                   want.data, want.ctl, want.frc, want.bsy, want.rdy);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_accept(output bit ok);
    bit acc;
    int k;
    acc = 0;
    k   = 0;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    ok = acc;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout t=%0t: in_ready=%b after %0d clk, want 1", $time, in_ready, k);
    end
  endtask

  task automatic send_frame(input int len, input int gap_pct, input int abort_at, input bit tog);
    bit ok;
    for (int i = 0; i < len; i++) begin
      if (i > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 0;
        step(1);
      end
      in_valid = 1;
      in_data  = fbuf[i];
      in_last  = (i == len - 1);
`ifdef TX_SEQ_ERROR_PROP_EN
      in_error = err_mask[i];
`endif
      wait_accept(ok);
      if (!ok) begin
        in_valid = 0;
        in_last  = 0;
        return;
      end
      if (i == abort_at) begin
        in_valid = 0;
        in_last  = 0;
        rst_n    = 0;
        step(2);
        rst_n    = 1;
        return;
      end
      if (tog) tx_en = 1'($urandom_range(0, 1));
    end
    in_valid = 0;
    in_last  = 0;
`ifdef TX_SEQ_ERROR_PROP_EN
    in_error = 0;
`endif
  endtask

  task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    fbuf[0] = a; fbuf[1] = b; fbuf[2] = c;
  endtask

  initial begin
    int len;
    rst_n    = 1;
    tx_en    = 0;
    in_valid = 0;
    in_data  = '0;
    in_last  = 0;
`ifdef TX_SEQ_ERROR_PROP_EN
    in_error = 0;
    err_mask = '0;
`endif
    #2;
    rst_n  = 0;
    mon_on = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;

    // idle only
    step(20);

    // 4-byte and 3-byte frames
    tx_en = 1;
    load3(8'h11, 8'h22, 8'h33); fbuf[3] = 8'h44;
    send_frame(4, 0, -1, 0);
    step(6);
    load3(8'hAA, 8'hBB, 8'hCC);
    send_frame(3, 0, -1, 0);
    step(3);

    // back-to-back frames with in_valid held high
    load3(8'h01, 8'h02, 8'h03);
    send_frame(2, 0, -1, 0);
    send_frame(3, 0, -1, 0);
    send_frame(1, 0, -1, 0);
    step(4);

    // underrun between every byte, then reset in the middle of a payload
    load3(8'h5A, 8'hA5, 8'h3C); fbuf[3] = 8'hC3;
    send_frame(4, 100, -1, 0);
    step(2);
    fbuf[3] = 8'h77; fbuf[4] = 8'h88; fbuf[5] = 8'h99;
    send_frame(6, 0, 2, 0);
    tx_en = 1;
    step(5);

`ifdef TX_SEQ_ERROR_PROP_EN
    load3(8'h55, 8'h66, 8'h77);
    err_mask = 16'h0002;
    send_frame(3, 0, -1, 0);
    err_mask = '0;
    step(4);
`endif

    for (int f = 0; f < 60; f++) begin
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom);
`ifdef TX_SEQ_ERROR_PROP_EN
      err_mask = 16'($urandom & $urandom);
`endif
      if ($urandom_range(0, 3) == 0) begin
        tx_en    = 0;
        in_valid = 1;
        in_data  = fbuf[0];
        in_last  = (len == 1);
        step(int'($urandom_range(1, 5)));
      end
      tx_en = 1;
      send_frame(len, int'($urandom_range(0, 30)),
                 (f % 20 == 19) ? int'($urandom_range(0, len - 1)) : -1, 1);
      tx_en = 1'($urandom_range(0, 1));
      step(int'($urandom_range(0, 6)));
    end

    tx_en = 0;
    step(12);
    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
